// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a 1-cycle read tag.
// Define RAM_ARB_PERF_EN to add the saturating CONFLICT_CNT counter and port.
module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 34
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A_REQ,
  input  logic          B_REQ,
  input  logic          A_WE,
  input  logic          B_WE,
  input  logic [AW-1:0] A_ADR,
  input  logic [AW-1:0] B_ADR,
  input  logic [DW-1:0] A_D,
  input  logic [DW-1:0] B_D,
  output logic          A_GNT,
  output logic          B_GNT,
  output logic          A_RVALID,
  output logic          B_RVALID,
  output logic [DW-1:0] A_Q,
  output logic [DW-1:0] B_Q,
  output logic [AW-1:0] RAM_ADR,
  output logic [DW-1:0] RAM_D,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_Q
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [15:0]   CONFLICT_CNT
`endif
);

  logic          pri_p0;
  logic          tag_vld_p0;
  logic          tag_port_p0;
  logic [AW-1:0] adr_hold_p0;
  logic [DW-1:0] d_hold_p0;
  logic [DW-1:0] a_q_p0;
  logic [DW-1:0] b_q_p0;
  logic          a_gnt;
  logic          b_gnt;
  logic          rd_gnt;
  logic          a_rvld;
  logic          b_rvld;

  // Stage 0: combinational arbitration and RAM port mux
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!RST) begin
      if (A_REQ && (!B_REQ || !pri_p0)) a_gnt = 1'b1;
      else if (B_REQ)                   b_gnt = 1'b1;
    end
  end

  assign rd_gnt = (a_gnt && !A_WE) || (b_gnt && !B_WE);

  always_comb begin
    RAM_WE  = 1'b0;
    RAM_ADR = adr_hold_p0;
    RAM_D   = d_hold_p0;
    if (RST) begin
      RAM_ADR = '0;
      RAM_D   = '0;
    end else if (a_gnt) begin
      RAM_WE  = A_WE;
      RAM_ADR = A_ADR;
      RAM_D   = A_D;
    end else if (b_gnt) begin
      RAM_WE  = B_WE;
      RAM_ADR = B_ADR;
      RAM_D   = B_D;
    end
  end

  assign A_GNT = a_gnt;
  assign B_GNT = b_gnt;

  // Stage 1: read tag returns RAM_Q to the requesting port
  assign a_rvld   = !RST && tag_vld_p0 && !tag_port_p0;
  assign b_rvld   = !RST && tag_vld_p0 &&  tag_port_p0;
  assign A_RVALID = a_rvld;
  assign B_RVALID = b_rvld;
  assign A_Q      = RST ? '0 : (a_rvld ? RAM_Q : a_q_p0);
  assign B_Q      = RST ? '0 : (b_rvld ? RAM_Q : b_q_p0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pri_p0      <= 1'b0;
      tag_vld_p0  <= 1'b0;
      tag_port_p0 <= 1'b0;
      adr_hold_p0 <= '0;
      d_hold_p0   <= '0;
      a_q_p0      <= '0;
      b_q_p0      <= '0;
    end else begin
      if (a_gnt)      pri_p0 <= 1'b1;
      else if (b_gnt) pri_p0 <= 1'b0;
      tag_vld_p0  <= rd_gnt;
      tag_port_p0 <= b_gnt;
      if (a_gnt || b_gnt) begin
        adr_hold_p0 <= RAM_ADR;
        d_hold_p0   <= RAM_D;
      end
      if (a_rvld) a_q_p0 <= RAM_Q;
      if (b_rvld) b_q_p0 <= RAM_Q;
    end
  end

`ifdef RAM_ARB_PERF_EN
  logic [15:0] cnt_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST)                 cnt_p0 <= '0;
    else if (A_REQ && B_REQ) cnt_p0 <= sat_inc16(cnt_p0);
  end

  assign CONFLICT_CNT = RST ? 16'h0 : cnt_p0;
`endif

endmodule
